// File: rtl/power_cmd_scheduler.sv
// power_cmd_scheduler: round-robin shutdown sequencer for five power domains.
// Issues one SD opcode at a time, then RESTORE on wake, and times out on ack.
module power_cmd_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] sd_req,
    input  logic [4:0] wake_req,
    input  logic       power_ack,
    output logic [7:0] cmd_bus,
    output logic [4:0] down_vec,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DOWN,
        WAIT_ACK
    } state_e;

    localparam logic [7:0] OP_SD_BASE = 8'h38;
    localparam logic [7:0] OP_RESTORE = 8'h3D;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q;
    logic [2:0]       rr_ptr_q;
    logic [2:0]       grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_q;
    logic [4:0]       down_q;
    logic             done_q;
    logic             err_q;

    logic [4:0]       eligible;
    logic             grant_vld;
    logic [2:0]       grant_idx;
    logic [2:0]       scan_idx;

    // Domain index successor with 4 wrapping back to 0.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // Round-robin search: first eligible domain at or after rr_ptr_q.
    always_comb begin
        eligible  = sd_req & ~wake_req;
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < 5; k++) begin
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // Sequencer FSM; every output is a register, cmd/done default to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 3'd0;
            grant_q  <= 3'd0;
            cnt_q    <= '0;
            cmd_q    <= 8'h00;
            down_q   <= 5'b00000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cmd_q  <= 8'h00;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        cmd_q   <= OP_SD_BASE + {5'd0, grant_idx};
                        down_q  <= 5'b00001 << grant_idx;
                        grant_q <= grant_idx;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= DOWN;
                    end
                end
                DOWN: begin
                    if (|(wake_req & down_q)) begin
                        cmd_q   <= OP_RESTORE;
                        cnt_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (power_ack) begin
                        down_q   <= 5'b00000;
                        done_q   <= 1'b1;
                        rr_ptr_q <= wrap_inc(grant_q);
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == ACK_LAST) begin
                            err_q    <= 1'b1;
                            down_q   <= 5'b00000;
                            rr_ptr_q <= wrap_inc(grant_q);
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_bus     = cmd_q;
    assign down_vec    = down_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_power_cmd_scheduler.sv
// tb_power_cmd_scheduler: scenario tasks plus a randomized transaction run
// checked against a transaction-level model of the sequencer.
module tb_power_cmd_scheduler;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] sd_req;
    logic [4:0] wake_req;
    logic       power_ack;
    logic [7:0] cmd_bus;
    logic [4:0] down_vec;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int m_rr  = 0;
    bit m_err = 1'b0;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    power_cmd_scheduler #(
        .SETTLE_CYCLES(SETTLE),
        .ACK_TIMEOUT(TMO),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sd_req(sd_req),
        .wake_req(wake_req),
        .power_ack(power_ack),
        .cmd_bus(cmd_bus),
        .down_vec(down_vec),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Model: first eligible domain scanning from rr, -1 if none.
    function automatic int pick(input logic [4:0] elig, input int rr);
        for (int k = 0; k < 5; k++) begin
            if (elig[(rr + k) % 5]) return (rr + k) % 5;
        end
        return -1;
    endfunction

    function automatic logic [7:0] sd_op(input int d);
        return 8'(8'h38 + d);
    endfunction

    function automatic logic [4:0] oh(input int d);
        return 5'(1 << d);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        sd_req = 5'd0;
        wake_req = 5'd0;
        power_ack = 1'b0;
        step_n(2);
        reset = 1'b0;
        m_rr = 0;
        m_err = 1'b0;
    endtask

    // Stimulus only: grant domain d from IDLE and run it into WAIT_ACK.
    task automatic drive_to_wait(input int d);
        sd_req = oh(d);
        step();
        sd_req = 5'd0;
        wake_req = oh(d);
        step_n(SETTLE + 1);
        wake_req = 5'd0;
    endtask

    task automatic ack_once();
        power_ack = 1'b1;
        step();
        power_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({cmd_bus, down_vec, busy, done, timeout_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0",
                     {cmd_bus, down_vec, busy, done, timeout_err});
        end
        step();
        total++;
        if ({cmd_bus, down_vec, busy} !== 14'd0) begin
            bad++;
            $display("FAIL idle_out got=%h exp=0", {cmd_bus, down_vec, busy});
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        sd_req = 5'b00010;
        step();
        sd_req = 5'b00000;
        total++;
        if (cmd_bus !== 8'h39 || down_vec !== 5'b00010 || busy !== 1'b1) begin
            bad++;
            $display("FAIL grant_gprs got cmd=%h down=%b busy=%b exp 39/00010/1",
                     cmd_bus, down_vec, busy);
        end
        step();
        total++;
        if (cmd_bus !== 8'h00 || down_vec !== 5'b00010) begin
            bad++;
            $display("FAIL grant_pulse got cmd=%h down=%b exp 00/00010",
                     cmd_bus, down_vec);
        end
    endtask

    task automatic test_round_robin();
        int d0;
        int exp;
        do_reset();
        d0 = done_cnt;
        sd_req = 5'b10101;
        for (int s = 0; s < 4; s++) begin
            exp = pick(5'b10101, m_rr);
            step();
            total++;
            if (cmd_bus !== sd_op(exp) || down_vec !== oh(exp)) begin
                bad++;
                $display("FAIL rr_grant%0d got cmd=%h down=%b exp %h/%b",
                         s, cmd_bus, down_vec, sd_op(exp), oh(exp));
            end
            wake_req = oh(exp);
            step_n(SETTLE + 1);
            wake_req = 5'd0;
            total++;
            if (cmd_bus !== 8'h3D) begin
                bad++;
                $display("FAIL rr_restore%0d got=%h exp=3d", s, cmd_bus);
            end
            step_n(2);
            power_ack = 1'b1;
            step();
            power_ack = 1'b0;
            total++;
            if (done !== 1'b1 || down_vec !== 5'd0) begin
                bad++;
                $display("FAIL rr_done%0d got done=%b down=%b exp 1/0",
                         s, done, down_vec);
            end
            m_rr = (exp + 1) % 5;
        end
        sd_req = 5'd0;
        step();
        total++;
        if (done_cnt - d0 !== 4) begin
            bad++;
            $display("FAIL rr_done_count got=%0d exp=4", done_cnt - d0);
        end
    endtask

    task automatic test_wake_in_settle();
        do_reset();
        sd_req = 5'b00010;
        step();
        sd_req = 5'd0;
        wake_req = 5'b00010;
        for (int i = 1; i <= SETTLE; i++) begin
            step();
            total++;
            if (cmd_bus !== 8'h00) begin
                bad++;
                $display("FAIL settle_wake c%0d got=%h exp=00", i, cmd_bus);
            end
        end
        step();
        total++;
        if (cmd_bus !== 8'h3D) begin
            bad++;
            $display("FAIL down_restore got=%h exp=3d", cmd_bus);
        end
        wake_req = 5'd0;
        step();
        total++;
        if (cmd_bus !== 8'h00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restore_pulse got cmd=%h busy=%b exp 00/1",
                     cmd_bus, busy);
        end
        ack_once();
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL settle_done got done=%b busy=%b exp 1/0", done, busy);
        end
    endtask

    task automatic test_other_wake();
        do_reset();
        sd_req = 5'b01000;
        step();
        total++;
        if (cmd_bus !== 8'h3B) begin
            bad++;
            $display("FAIL grant_memx got=%h exp=3b", cmd_bus);
        end
        sd_req = 5'b00001;
        step_n(SETTLE);
        wake_req = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (cmd_bus !== 8'h00 || down_vec !== 5'b01000) begin
                bad++;
                $display("FAIL other_wake c%0d got cmd=%h down=%b exp 00/01000",
                         i, cmd_bus, down_vec);
            end
        end
        wake_req = 5'b01000;
        step();
        total++;
        if (cmd_bus !== 8'h3D) begin
            bad++;
            $display("FAIL own_wake got=%h exp=3d", cmd_bus);
        end
        wake_req = 5'd0;
        ack_once();
        step();
        total++;
        if (cmd_bus !== 8'h38 || down_vec !== 5'b00001) begin
            bad++;
            $display("FAIL pending_grant got cmd=%h down=%b exp 38/00001",
                     cmd_bus, down_vec);
        end
    endtask

    task automatic test_timeout();
        int d0;
        do_reset();
        drive_to_wait(2);
        d0 = done_cnt;
        for (int i = 1; i < TMO; i++) begin
            step();
            total++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL tmo_early c%0d got err=%b busy=%b exp 0/1",
                         i, timeout_err, busy);
            end
        end
        step();
        total++;
        if (timeout_err !== 1'b1 || down_vec !== 5'd0 || busy !== 1'b0 ||
            done_cnt != d0) begin
            bad++;
            $display("FAIL tmo_fire got err=%b down=%b busy=%b dones=%0d exp 1/0/0/0",
                     timeout_err, down_vec, busy, done_cnt - d0);
        end
        sd_req = 5'b00110;
        step();
        sd_req = 5'd0;
        total++;
        if (cmd_bus !== 8'h39 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_regrant got cmd=%h err=%b exp 39/1",
                     cmd_bus, timeout_err);
        end
    endtask

    task automatic test_ack_at_threshold();
        do_reset();
        drive_to_wait(4);
        step_n(TMO - 1);
        ack_once();
        total++;
        if (done !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ack_thresh got done=%b err=%b busy=%b exp 1/0/0",
                     done, timeout_err, busy);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive_to_wait(0);
        ack_once();
        drive_to_wait(1);
        step_n(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({cmd_bus, down_vec, busy, done, timeout_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_wait got=%h exp=0",
                     {cmd_bus, down_vec, busy, done, timeout_err});
        end
        sd_req = 5'b00011;
        step();
        sd_req = 5'd0;
        total++;
        if (cmd_bus !== 8'h38 || down_vec !== 5'b00001) begin
            bad++;
            $display("FAIL reset_rr got cmd=%h down=%b exp 38/00001",
                     cmd_bus, down_vec);
        end
    endtask

    task automatic test_random();
        logic [4:0] sd;
        logic [4:0] wk;
        int exp;
        int dly;
        int nd;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            sd = 5'($urandom);
            wk = 5'($urandom) & 5'($urandom);
            sd_req = sd;
            wake_req = wk;
            power_ack = 1'($urandom);
            exp = pick(sd & ~wk, m_rr);
            step();
            if (exp < 0) begin
                total++;
                if (cmd_bus !== 8'h00 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_idle t%0d got cmd=%h busy=%b exp 00/0",
                             t, cmd_bus, busy);
                end
                continue;
            end
            total++;
            if (cmd_bus !== sd_op(exp) || down_vec !== oh(exp) || done !== 1'b0) begin
                bad++;
                $display("FAIL rnd_grant t%0d got cmd=%h down=%b done=%b exp %h/%b/0",
                         t, cmd_bus, down_vec, done, sd_op(exp), oh(exp));
            end
            for (int i = 0; i < SETTLE; i++) begin
                sd_req = 5'($urandom);
                wake_req = 5'($urandom);
                power_ack = 1'($urandom);
                step();
                total++;
                if (cmd_bus !== 8'h00 || down_vec !== oh(exp)) begin
                    bad++;
                    $display("FAIL rnd_settle t%0d got cmd=%h down=%b exp 00/%b",
                             t, cmd_bus, down_vec, oh(exp));
                end
            end
            nd = $urandom_range(0, 3);
            for (int i = 0; i < nd; i++) begin
                wake_req = 5'($urandom) & ~oh(exp);
                power_ack = 1'($urandom);
                step();
                total++;
                if (cmd_bus !== 8'h00 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_down t%0d got cmd=%h busy=%b exp 00/1",
                             t, cmd_bus, busy);
                end
            end
            wake_req = oh(exp) | 5'($urandom);
            power_ack = 1'b0;
            step();
            wake_req = 5'd0;
            total++;
            if (cmd_bus !== 8'h3D) begin
                bad++;
                $display("FAIL rnd_restore t%0d got=%h exp=3d", t, cmd_bus);
            end
            dly = $urandom_range(0, TMO + 1);
            if (dly < TMO) begin
                step_n(dly);
                ack_once();
                total++;
                if (done !== 1'b1 || down_vec !== 5'd0 || timeout_err !== m_err) begin
                    bad++;
                    $display("FAIL rnd_ack t%0d got done=%b down=%b err=%b exp 1/0/%b",
                             t, done, down_vec, timeout_err, m_err);
                end
            end else begin
                step_n(TMO);
                m_err = 1'b1;
                total++;
                if (done !== 1'b0 || down_vec !== 5'd0 || timeout_err !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_tmo t%0d got done=%b down=%b err=%b exp 0/0/1",
                             t, done, down_vec, timeout_err);
                end
            end
            m_rr = (exp + 1) % 5;
        end
        sd_req = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_wake_in_settle();
        test_other_wake();
        test_timeout();
        test_ack_at_threshold();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/power_cmd_scheduler.md
Name: power_cmd_scheduler

Overview:
- Always-on sequencer that sits between the per-domain power-management requesters and the power controller's 8-bit instruction input.
- Arbitrates shutdown requests from five domains round-robin and issues exactly one *_SD opcode at a time.
- Holds the selected domain down until that domain requests wake, then issues RESTORE and waits for power_ack.
- Flags a sticky error if power_ack does not arrive within a bounded time.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after issuing an SD opcode before a wake request is honoured (must be >= 2).
- ACK_TIMEOUT, 16, maximum cycles in WAIT_ACK before the timeout error is raised.
- CNT_W, 8, width of the shared settle/timeout counter; both parameters must be < 2^CNT_W.

Ports:
- clock  input  1  single system clock; all state is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sd_req  input  5  level shutdown requests; bit0 inst, bit1 gprs, bit2 mult, bit3 memx, bit4 memy.
- wake_req  input  5  level wake requests, same bit order.
- power_ack  input  1  restore-complete pulse from the power controller.
- cmd_bus  output  8  registered opcode to the power controller; 8'h00 when idle.
- down_vec  output  5  one-hot; marks the domain currently shut down or in transition.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when power_ack is received in WAIT_ACK.
- timeout_err  output  1  sticky; cleared only by reset.

Behaviour:
- Reset: all outputs are 0. state=IDLE, rr_ptr=0, counter=0.
- Opcode map: inst 8'h38, gprs 8'h39, mult 8'h3A, memx 8'h3B, memy 8'h3C, RESTORE 8'h3D.
- cmd_bus carries a non-zero value for exactly one cycle per command and returns to 8'h00 on the next cycle.
- States: IDLE, SETTLE, DOWN, WAIT_ACK.
- IDLE:
  - eligible[i] = sd_req[i] & ~wake_req[i].
  - If any bit is eligible, grant the first eligible bit at or after rr_ptr, wrapping 4->0.
  - On the grant edge: cmd_bus <= opcode of the granted domain, down_vec <= onehot(grant), counter <= 0, state <= SETTLE.
  - Command latency from request to opcode is 1 cycle.
- SETTLE:
  - counter increments each cycle.
  - When counter == SETTLE_CYCLES-1: state <= DOWN.
  - wake_req is ignored in this state.
- DOWN:
  - Stays in DOWN until wake_req & down_vec is non-zero.
  - Then: cmd_bus <= 8'h3D for one cycle, counter <= 0, state <= WAIT_ACK.
  - wake_req bits for other domains are ignored.
  - sd_req bits for other domains stay pending (level-held) and are not granted.
- WAIT_ACK:
  - power_ack=1: down_vec <= 0, done <= 1 for one cycle, rr_ptr <= granted index+1 (4 wraps to 0), state <= IDLE.
  - Else counter increments. When counter == ACK_TIMEOUT-1 with no ack: timeout_err <= 1, down_vec <= 0, rr_ptr advances, state <= IDLE, no done pulse.
  - power_ack arriving on the same cycle as the timeout threshold counts as success: no error, done pulses.
- power_ack in any state other than WAIT_ACK is ignored.
- Only one domain is ever down at a time.
- A requester that deasserts sd_req after being granted is still sequenced to completion; the grant is not withdrawn.
- Reset asserted in any state returns every output and internal register to its reset value on that edge; no RESTORE is issued.
- timeout_err does not block further operation.

Test Plan:
- Reset, then sd_req=5'b00010 for one cycle -> next cycle cmd_bus=8'h39, down_vec=5'b00010, busy=1; the cycle after, cmd_bus=8'h00.
- sd_req=5'b10101 held, each served with wake plus an ack 3 cycles after RESTORE -> grant order inst(8'h38), mult(8'h3A), memy(8'h3C), inst again; done pulses once per service.
- Granted gprs, wake_req=5'b00010 asserted during SETTLE (cycles 1..3) -> no 8'h3D issued; 8'h3D appears exactly 1 cycle after entering DOWN while wake is held.
- DOWN on memx, wake_req=5'b00001 -> stays in DOWN, cmd_bus=8'h00; wake_req=5'b01000 -> cmd_bus=8'h3D for 1 cycle.
- WAIT_ACK with power_ack never asserted -> timeout_err=1 after 16 cycles, down_vec=0, busy=0, no done pulse; the next sd_req is still granted normally.
- Reset pulsed while in WAIT_ACK -> next cycle all outputs are 0; a following sd_req=5'b00001 is granted inst (rr_ptr back to 0).
